// File: rtl/ra_2r1w_sdr_param_pkg.sv
// ra_2r1w_sdr_param_pkg: shared definitions for the 2R1W SDR register-file wrapper.
//   ra_state_e     : wrapper FSM state (init walk / ready); encodings match legacy
//                    RA_ST_INIT / RA_ST_RDY
//   RA_ADR_W_DFLT  : default address width
//   RA_DAT_W_DFLT  : default data width
//   GENMODE        : generation mode selector kept for toysram compatibility
package ra_2r1w_sdr_param_pkg;

  typedef enum logic [0:0] {
    RA_ST_INIT = 1'b0,
    RA_ST_RDY  = 1'b1
  } ra_state_e;

  localparam int unsigned RA_ADR_W_DFLT = 5;
  localparam int unsigned RA_DAT_W_DFLT = 32;
  localparam int unsigned GENMODE       = 0;

endpackage

// File: rtl/ra_2r1w_sdr_param_storage.sv
// ra_2r1w_storage: behavioural DEPTH x W storage array, no reset.
//   clk        : clock, write commits on posedge
//   rd_adr_0/1 : read addresses (combinational read)
//   rd_dat_0/1 : read data
//   wr_enb     : write enable
//   wr_adr     : write address
//   wr_dat     : write data
module ra_2r1w_storage
  import ra_2r1w_sdr_param_pkg::*;
#(
  parameter int unsigned ADR_W = RA_ADR_W_DFLT,
  parameter int unsigned W     = RA_DAT_W_DFLT
) (
  input  logic             clk,
  input  logic [ADR_W-1:0] rd_adr_0,
  output logic [W-1:0]     rd_dat_0,
  input  logic [ADR_W-1:0] rd_adr_1,
  output logic [W-1:0]     rd_dat_1,
  input  logic             wr_enb,
  input  logic [ADR_W-1:0] wr_adr,
  input  logic [W-1:0]     wr_dat
);

  localparam int unsigned DEPTH = 2**ADR_W;

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_enb) begin
      mem_q[wr_adr] <= wr_dat;
    end
  end

  assign rd_dat_0 = mem_q[rd_adr_0];
  assign rd_dat_1 = mem_q[rd_adr_1];

endmodule

// File: rtl/ra_2r1w_sdr_param.sv
// ra_2r1w_sdr_param: 2R1W SDR register-file wrapper, parametrised depth/width.
//   Stages read/write requests, drives ra_2r1w_storage, bypasses same-cycle
//   write data to matching reads, zero-fills the array after reset.
// Ports:
//   clk                 : clock
//   reset               : asynchronous active-low reset
//   ready               : requests accepted (init walk complete)
//   rd_enb_n/rd_adr_n   : read port n request
//   rd_dat_n/rd_vld_n   : read port n data and valid strobe
//   wr_enb_0/adr_0/dat_0: write request
//   rd_perr_0/1         : read parity error, aligned with rd_vld_n
//   perr_stky           : sticky parity error
// Configuration: define RA_PARITY_EN to store/check an even-parity bit per
// entry; otherwise the parity outputs are tied to 0.
module ra_2r1w_sdr_param
  import ra_2r1w_sdr_param_pkg::*;
#(
  parameter int unsigned ADR_W         = RA_ADR_W_DFLT,
  parameter int unsigned DAT_W         = RA_DAT_W_DFLT,
  parameter int unsigned LATCHRD       = 1,
  parameter int unsigned INIT_ON_RESET = 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic             ready,
  input  logic             rd_enb_0,
  input  logic [0:ADR_W-1] rd_adr_0,
  output logic [0:DAT_W-1] rd_dat_0,
  output logic             rd_vld_0,
  input  logic             rd_enb_1,
  input  logic [0:ADR_W-1] rd_adr_1,
  output logic [0:DAT_W-1] rd_dat_1,
  output logic             rd_vld_1,
  input  logic             wr_enb_0,
  input  logic [0:ADR_W-1] wr_adr_0,
  input  logic [0:DAT_W-1] wr_dat_0,
  output logic             rd_perr_0,
  output logic             rd_perr_1,
  output logic             perr_stky
);

`ifdef RA_PARITY_EN
  localparam int unsigned SW = DAT_W + 1;
`else
  localparam int unsigned SW = DAT_W;
`endif

  ra_state_e        state_q, state_d;
  logic [ADR_W-1:0] cnt_q, cnt_d;

  logic [1:0]       re_q;
  logic [ADR_W-1:0] ra0_q, ra1_q, wa_q;
  logic             we_q;
  logic [DAT_W-1:0] wd_q;

  logic             init;
  logic             s_we;
  logic [ADR_W-1:0] s_wa;
  logic [SW-1:0]    s_wd, s_wd_rdy;
  logic [SW-1:0]    arr0, arr1;
  logic [DAT_W-1:0] arr0_dat, arr1_dat;
  logic             byp0, byp1;
  logic [DAT_W-1:0] d0, d1;
  logic             perr0_raw, perr1_raw;

  // Init walk: one zero write per cycle, leave after address DEPTH-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == RA_ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) begin
        state_d = RA_ST_RDY;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= (INIT_ON_RESET != 0) ? RA_ST_INIT : RA_ST_RDY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign init  = (state_q == RA_ST_INIT);
  assign ready = (state_q == RA_ST_RDY);

  // Request staging; held cleared while not ready so init ignores requests.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      re_q  <= '0;
      ra0_q <= '0;
      ra1_q <= '0;
      we_q  <= 1'b0;
      wa_q  <= '0;
      wd_q  <= '0;
    end else if (!ready) begin
      re_q  <= '0;
      ra0_q <= '0;
      ra1_q <= '0;
      we_q  <= 1'b0;
      wa_q  <= '0;
      wd_q  <= '0;
    end else begin
      re_q  <= {rd_enb_1, rd_enb_0};
      ra0_q <= rd_adr_0;
      ra1_q <= rd_adr_1;
      we_q  <= wr_enb_0;
      wa_q  <= wr_adr_0;
      wd_q  <= wr_dat_0;
    end
  end

`ifdef RA_PARITY_EN
  assign s_wd_rdy = {wd_q, ^wd_q};
`else
  assign s_wd_rdy = wd_q;
`endif

  assign s_we = init | we_q;
  assign s_wa = init ? cnt_q : wa_q;
  assign s_wd = init ? '0 : s_wd_rdy;

  ra_2r1w_storage #(
    .ADR_W (ADR_W),
    .W     (SW)
  ) u_stor (
    .clk      (clk),
    .rd_adr_0 (ra0_q),
    .rd_dat_0 (arr0),
    .rd_adr_1 (ra1_q),
    .rd_dat_1 (arr1),
    .wr_enb   (s_we),
    .wr_adr   (s_wa),
    .wr_dat   (s_wd)
  );

  assign arr0_dat = arr0[SW-1 -: DAT_W];
  assign arr1_dat = arr1[SW-1 -: DAT_W];

  assign byp0 = re_q[0] & we_q & (ra0_q == wa_q);
  assign byp1 = re_q[1] & we_q & (ra1_q == wa_q);
  assign d0   = byp0 ? wd_q : arr0_dat;
  assign d1   = byp1 ? wd_q : arr1_dat;

`ifdef RA_PARITY_EN
  // Checked on the array word; bypassed data never flags.
  assign perr0_raw = re_q[0] & ~byp0 & (^arr0);
  assign perr1_raw = re_q[1] & ~byp1 & (^arr1);
`else
  assign perr0_raw = 1'b0;
  assign perr1_raw = 1'b0;
`endif

  generate
    if (LATCHRD != 0) begin : g_latch
      logic [DAT_W-1:0] dat0_q, dat1_q;
      logic [1:0]       vld_q, perr_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          dat0_q <= '0;
          dat1_q <= '0;
          vld_q  <= '0;
          perr_q <= '0;
        end else begin
          vld_q  <= re_q;
          perr_q <= {perr1_raw, perr0_raw};
          if (re_q[0]) dat0_q <= d0;
          if (re_q[1]) dat1_q <= d1;
        end
      end

      assign rd_dat_0  = dat0_q;
      assign rd_dat_1  = dat1_q;
      assign rd_vld_0  = vld_q[0];
      assign rd_vld_1  = vld_q[1];
      assign rd_perr_0 = perr_q[0];
      assign rd_perr_1 = perr_q[1];
    end else begin : g_comb
      // Gated to zero when idle so the outputs read 0 through reset.
      assign rd_dat_0  = re_q[0] ? d0 : '0;
      assign rd_dat_1  = re_q[1] ? d1 : '0;
      assign rd_vld_0  = re_q[0];
      assign rd_vld_1  = re_q[1];
      assign rd_perr_0 = perr0_raw;
      assign rd_perr_1 = perr1_raw;
    end
  endgenerate

`ifdef RA_PARITY_EN
  logic stky_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stky_q <= 1'b0;
    end else begin
      stky_q <= stky_q | rd_perr_0 | rd_perr_1;
    end
  end

  assign perr_stky = stky_q;
`else
  assign perr_stky = 1'b0;
`endif

endmodule

// File: tb/tb_ra_2r1w_sdr_param.sv
module tb_ra_2r1w_sdr_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // u0: defaults (ADR_W=5, DAT_W=32, LATCHRD=1)
  logic        rdy, re0, re1, we, v0, v1, pe0, pe1, stky;
  logic [4:0]  ra0, ra1, wa;
  logic [31:0] wd, d0, d1;
  // u1: ADR_W=6, DAT_W=72, LATCHRD=0
  logic        b_rdy, b_re0, b_re1, b_we, b_v0, b_v1, b_pe0, b_pe1, b_stky;
  logic [5:0]  b_ra0, b_ra1, b_wa;
  logic [71:0] b_wd, b_d0, b_d1;

  ra_2r1w_sdr_param u0 (
    .clk(clk), .reset(rst_n), .ready(rdy),
    .rd_enb_0(re0), .rd_adr_0(ra0), .rd_dat_0(d0), .rd_vld_0(v0),
    .rd_enb_1(re1), .rd_adr_1(ra1), .rd_dat_1(d1), .rd_vld_1(v1),
    .wr_enb_0(we), .wr_adr_0(wa), .wr_dat_0(wd),
    .rd_perr_0(pe0), .rd_perr_1(pe1), .perr_stky(stky)
  );

  ra_2r1w_sdr_param #(.ADR_W(6), .DAT_W(72), .LATCHRD(0), .INIT_ON_RESET(1)) u1 (
    .clk(clk), .reset(rst_n), .ready(b_rdy),
    .rd_enb_0(b_re0), .rd_adr_0(b_ra0), .rd_dat_0(b_d0), .rd_vld_0(b_v0),
    .rd_enb_1(b_re1), .rd_adr_1(b_ra1), .rd_dat_1(b_d1), .rd_vld_1(b_v1),
    .wr_enb_0(b_we), .wr_adr_0(b_wa), .wr_dat_0(b_wd),
    .rd_perr_0(b_pe0), .rd_perr_1(b_pe1), .perr_stky(b_stky)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re0;
    logic [4:0]  ra0;
    logic        re1;
    logic [4:0]  ra1;
    logic        v0;
    logic [31:0] d0;
    logic        v1;
    logic [31:0] d1;
  } vec_t;

  localparam int NV = 13;
  vec_t vt[NV];

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic w, logic [4:0] a, logic [31:0] dw,
                              logic r0, logic [4:0] a0, logic r1, logic [4:0] a1,
                              logic ev0, logic [31:0] ed0, logic ev1, logic [31:0] ed1);
    vec_t v;
    v.we = w; v.wa = a; v.wd = dw;
    v.re0 = r0; v.ra0 = a0; v.re1 = r1; v.ra1 = a1;
    v.v0 = ev0; v.d0 = ed0; v.v1 = ev1; v.d1 = ed1;
    return v;
  endfunction

  task automatic idle0();
    re0 = 0; ra0 = '0; re1 = 0; ra1 = '0; we = 0; wa = '0; wd = '0;
  endtask

  task automatic idle1();
    b_re0 = 0; b_ra0 = '0; b_re1 = 0; b_ra1 = '0; b_we = 0; b_wa = '0; b_wd = '0;
  endtask

  task automatic drive0(input vec_t v);
    we = v.we; wa = v.wa; wd = v.wd;
    re0 = v.re0; ra0 = v.ra0; re1 = v.re1; ra1 = v.ra1;
  endtask

  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
  endtask

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog actual=timeout required=finish");
    summary();
    $finish;
  end

  initial begin
    int c0, c1, nv;

    //             we wa  wd            re0 ra0 re1 ra1   v0 d0            v1 d1
    vt[0]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  0, 0,    0, 32'h0,        0, 32'h0);
    vt[1]  = mk(0, 0,  32'h0,        1, 5,  1, 5,    1, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    vt[2]  = mk(0, 0,  32'h0,        0, 0,  0, 0,    0, 32'hDEADBEEF, 0, 32'hDEADBEEF);
    vt[3]  = mk(1, 10, 32'hA5A5A5A5, 0, 0,  0, 0,    0, 32'hDEADBEEF, 0, 32'hDEADBEEF);
    vt[4]  = mk(1, 9,  32'h12345678, 1, 9,  1, 10,   1, 32'h12345678, 1, 32'hA5A5A5A5);
    vt[5]  = mk(0, 0,  32'h0,        1, 9,  1, 9,    1, 32'h12345678, 1, 32'h12345678);
    vt[6]  = mk(1, 9,  32'h11111111, 0, 0,  0, 0,    0, 32'h12345678, 0, 32'h12345678);
    vt[7]  = mk(1, 9,  32'h22222222, 0, 0,  0, 0,    0, 32'h12345678, 0, 32'h12345678);
    vt[8]  = mk(0, 0,  32'h0,        1, 9,  1, 5,    1, 32'h22222222, 1, 32'hDEADBEEF);
    vt[9]  = mk(1, 31, 32'hCAFEF00D, 1, 31, 1, 31,   1, 32'hCAFEF00D, 1, 32'hCAFEF00D);
    vt[10] = mk(1, 0,  32'hFFFFFFFF, 1, 0,  1, 31,   1, 32'hFFFFFFFF, 1, 32'hCAFEF00D);
    vt[11] = mk(0, 0,  32'h0BAD0BAD, 1, 0,  0, 0,    1, 32'hFFFFFFFF, 0, 32'hCAFEF00D);
    vt[12] = mk(0, 0,  32'h0,        0, 0,  1, 9,    0, 32'hFFFFFFFF, 1, 32'h22222222);

    idle0();
    idle1();
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ready", {rdy, b_rdy}, 2'b00);
    chk("rst_vld", {v0, v1, b_v0, b_v1}, 4'b0);
    chk("rst_dat", {d0, d1}, 64'h0);
    chk("rst_dat_b", {b_d0, b_d1}, 144'h0);
    chk("rst_perr", {pe0, pe1, stky, b_pe0, b_pe1, b_stky}, 6'b0);

    // Init length: ready low for DEPTH cycles including the release cycle
    rst_n = 1'b1;
    c0 = 0; c1 = 0;
    for (int n = 0; n < 200 && !(rdy && b_rdy); n++) begin
      if (!rdy) c0++;
      if (!b_rdy) c1++;
      @(negedge clk);
    end
    chk("init_cycles_32", c0, 32);
    chk("init_cycles_64", c1, 64);

    // Every entry reads zero after init
    for (int i = 0; i < 34; i++) begin
      if (i >= 2) chk($sformatf("init_read_%0d", i - 2), {v0, d0, v1, d1}, {1'b1, 32'h0, 1'b1, 32'h0});
      if (i < 32) begin
        re0 = 1; ra0 = 5'(i); re1 = 1; ra1 = 5'(31 - i);
      end else begin
        idle0();
      end
      @(negedge clk);
    end

    // Table: write/read, bypass, back-to-back writes, hold behaviour
    for (int i = 0; i < NV + 2; i++) begin
      if (i >= 2) begin
        chk($sformatf("vec_%0d", i - 2), {v0, d0, v1, d1},
            {vt[i-2].v0, vt[i-2].d0, vt[i-2].v1, vt[i-2].d1});
        chk($sformatf("vec_perr_%0d", i - 2), {pe0, pe1, stky}, 3'b000);
      end
      if (i < NV) drive0(vt[i]);
      else idle0();
      @(negedge clk);
    end

    // Mid-init reset restarts the walk; requests during init are ignored
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", rdy, 1'b0);
    chk("async_rst_dat", {v0, d0}, {1'b0, 32'h0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    re0 = 1; ra0 = 5; re1 = 1; ra1 = 7; we = 1; wa = 5; wd = 32'hFFFF0000;
    nv = 0;
    for (int n = 0; n < 10; n++) begin
      if (v0 || v1) nv++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    c0 = 0;
    for (int n = 0; n < 200 && !rdy; n++) begin
      c0++;
      if (v0 || v1) nv++;
      @(negedge clk);
    end
    idle0();
    chk("midinit_cycles", c0, 32);
    repeat (2) begin
      if (v0 || v1) nv++;
      @(negedge clk);
    end
    chk("midinit_no_vld", nv, 0);
    re0 = 1; ra0 = 5; re1 = 1; ra1 = 7;
    @(negedge clk);
    idle0();
    @(negedge clk);
    chk("midinit_zero", {v0, d0, v1, d1}, {1'b1, 32'h0, 1'b1, 32'h0});

    // LATCHRD=0 instance: valid at T+1, top address, bypass
    for (int n = 0; n < 200 && !b_rdy; n++) @(negedge clk);
    chk("b_ready", b_rdy, 1'b1);
    b_we = 1; b_wa = 63; b_wd = 72'hAB_CDEF0123_456789AB;
    @(negedge clk);
    chk("b_wr_novld", {b_v0, b_v1}, 2'b00);
    idle1();
    b_re0 = 1; b_ra0 = 63; b_re1 = 1; b_ra1 = 63;
    @(negedge clk);
    chk("b_rd_63", {b_v0, b_d0, b_v1, b_d1}, {1'b1, 72'hAB_CDEF0123_456789AB, 1'b1, 72'hAB_CDEF0123_456789AB});
    idle1();
    @(negedge clk);
    chk("b_vld_drop", {b_v0, b_v1}, 2'b00);
    b_we = 1; b_wa = 0; b_wd = 72'h5A_0000FFFF_12345678; b_re0 = 1; b_ra0 = 0; b_re1 = 1; b_ra1 = 62;
    @(negedge clk);
    chk("b_bypass", {b_v0, b_d0, b_v1, b_d1}, {1'b1, 72'h5A_0000FFFF_12345678, 1'b1, 72'h0});
    idle1();
    @(negedge clk);

`ifdef RA_PARITY_EN
    u0.u_stor.mem_q[3] = u0.u_stor.mem_q[3] ^ 33'd1;
    re0 = 1; ra0 = 3;
    @(negedge clk);
    idle0();
    @(negedge clk);
    chk("perr_flag", {v0, pe0}, 2'b11);
    @(negedge clk);
    chk("perr_sticky", {pe0, stky}, 2'b01);
    we = 1; wa = 3; wd = 32'h5; re0 = 1; ra0 = 3;
    @(negedge clk);
    idle0();
    @(negedge clk);
    chk("perr_bypass", {v0, d0, pe0}, {1'b1, 32'h5, 1'b0});
`else
    chk("perr_tied", {pe0, pe1, stky, b_pe0, b_pe1, b_stky}, 6'b0);
`endif

    summary();
    $finish;
  end

endmodule
